// File: rtl/rtc_disp_sel.sv
// rtc_disp_sel: snapshots the six BCD RTC fields tear-free, selects a time or
// date view (auto toggle every AUTO_SEC RTC seconds or on key press) and
// drives the 24-bit BCD display word plus the decimal-point mask.
// Optional feature macro: RTC_DISP_12H_EN (12 h hour display with PM point).
module rtc_disp_sel #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned AUTO_SEC = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_press,
    input  logic [7:0]  sec,
    input  logic [7:0]  min,
    input  logic [7:0]  hour,
    input  logic [7:0]  day,
    input  logic [7:0]  mon,
    input  logic [7:0]  year,
    output logic [23:0] disp_data,
    output logic [5:0]  point,
    output logic        view_date,
    output logic        bcd_err
);

    localparam int unsigned HALF   = CLK_FREQ / 2;
    localparam int unsigned BW     = ($clog2(HALF + 1) > 0) ? $clog2(HALF + 1) : 1;
    localparam int unsigned CW     = ($clog2(AUTO_SEC + 1) > 0) ? $clog2(AUTO_SEC + 1) : 1;
    localparam logic [5:0]  PT_ON  = 6'b010100;

    typedef enum logic {TIME, DATE} view_t;

    view_t          state, state_nxt;
    logic [CW-1:0]  sec_cnt, sec_cnt_nxt;
    logic [47:0]    snap_in, cur, shadow;
    logic [7:0]     sec_seen;
    logic           sec_tick;
    logic [BW-1:0]  blink, blink_nxt;
    logic           blink_on;
    logic           bcd_bad;
    logic [7:0]     hour_disp;
    logic           pm;
    logic [5:0]     point_nxt;

    assign snap_in = {year, mon, day, hour, min, sec};

    // Capture every edge; promote to shadow only once two samples agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= '0;
            shadow <= '0;
        end else begin
            cur <= snap_in;
            if (cur == snap_in && cur != shadow)
                shadow <= cur;
        end
    end

    // Remember last seen shadow seconds to detect RTC second ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sec_seen <= '0;
        else     sec_seen <= shadow[7:0];
    end

    assign sec_tick = (shadow[7:0] != sec_seen);

    // View state register and second counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TIME;
            sec_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sec_cnt <= sec_cnt_nxt;
        end
    end

    // Next view: key press wins over the tick, so a coincident expiry toggles once.
    always_comb begin
        state_nxt   = state;
        sec_cnt_nxt = sec_cnt;
        if (key_press) begin
            state_nxt   = (state == TIME) ? DATE : TIME;
            sec_cnt_nxt = '0;
        end else if (sec_tick && AUTO_SEC != 0) begin
            if (32'(sec_cnt) + 32'd1 == AUTO_SEC) begin
                state_nxt   = (state == TIME) ? DATE : TIME;
                sec_cnt_nxt = '0;
            end else begin
                sec_cnt_nxt = sec_cnt + CW'(1);
            end
        end
    end

    // View output decode.
    always_comb begin
        view_date = (state == DATE);
    end

    // Blink counter next value: restart on tick, saturate at the half-second point.
    always_comb begin
        if (sec_tick)                 blink_nxt = '0;
        else if (blink == BW'(HALF))  blink_nxt = blink;
        else                          blink_nxt = blink + BW'(1);
        blink_on = (32'(blink_nxt) < HALF);
    end

    // Blink counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blink <= '0;
        else     blink <= blink_nxt;
    end

    // Flag any shadow nibble outside 0..9.
    always_comb begin
        bcd_bad = 1'b0;
        for (int unsigned i = 0; i < 12; i++)
            if (shadow[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end

    // Hour digits for the time view.
`ifdef RTC_DISP_12H_EN
    logic [7:0] hour_bin;
    logic [7:0] hour_12;
    always_comb begin
        hour_bin = {4'd0, shadow[23:20]} * 8'd10 + {4'd0, shadow[19:16]};
        pm       = (hour_bin >= 8'd12);
        if (hour_bin == 8'd0)      hour_12 = 8'd12;
        else if (hour_bin > 8'd12) hour_12 = hour_bin - 8'd12;
        else                       hour_12 = hour_bin;
        if (hour_12 >= 8'd10) hour_disp = {4'd1, 4'(hour_12 - 8'd10)};
        else                  hour_disp = {4'd0, hour_12[3:0]};
    end
`else
    always_comb begin
        hour_disp = shadow[23:16];
        pm        = 1'b0;
    end
`endif

    // Point mask for the current view.
    always_comb begin
        point_nxt = '0;
        if (state == DATE || blink_on) point_nxt = PT_ON;
        if (state == TIME && pm)       point_nxt[0] = 1'b1;
    end

    // Registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            point     <= '0;
            bcd_err   <= 1'b0;
        end else begin
            bcd_err <= bcd_bad;
            point   <= point_nxt;
            if (bcd_bad)            disp_data <= '0;
            else if (state == DATE) disp_data <= shadow[47:24];
            else                    disp_data <= {hour_disp, shadow[15:0]};
        end
    end

endmodule

// File: tb/tb_rtc_disp_sel.sv
// tb_rtc_disp_sel: directed and randomized checks of rtc_disp_sel against a
// behavioural reference model (CLK_FREQ=100, AUTO_SEC=3).
// Honours RTC_DISP_12H_EN when defined for the build.
module tb_rtc_disp_sel;

    localparam int unsigned CLK_FREQ = 100;
    localparam int unsigned AUTO_SEC = 3;
    localparam int unsigned HALF     = CLK_FREQ / 2;
`ifdef RTC_DISP_12H_EN
    localparam logic PM12 = 1'b1;
`else
    localparam logic PM12 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_press = 1'b0;
    logic [7:0]  sec, min, hour, day, mon, year;
    logic [23:0] disp_data;
    logic [5:0]  point;
    logic        view_date;
    logic        bcd_err;

    always #5 clk = ~clk;

    rtc_disp_sel #(.CLK_FREQ(CLK_FREQ), .AUTO_SEC(AUTO_SEC)) dut (
        .clk(clk), .rst(rst), .key_press(key_press),
        .sec(sec), .min(min), .hour(hour), .day(day), .mon(mon), .year(year),
        .disp_data(disp_data), .point(point), .view_date(view_date), .bcd_err(bcd_err)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what the display should show, derived from field rules.
    logic [47:0] m_cur, m_sh;
    logic [7:0]  m_prev_sec;
    bit          m_view;
    int unsigned m_secs, m_since;
    logic [23:0] m_disp;
    logic [5:0]  m_point;
    bit          m_err;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_reset();
        m_cur = '0; m_sh = '0; m_prev_sec = '0; m_view = 0;
        m_secs = 0; m_since = 0; m_disp = '0; m_point = '0; m_err = 0;
    endtask

    task automatic model_edge();
        logic [47:0] in_w;
        logic [7:0]  f, hd;
        bit          tick, ok, pm;
        int unsigned h, h12;
        if (rst) begin
            model_reset();
            return;
        end
        in_w = {year, mon, day, hour, min, sec};
        tick = (m_sh[7:0] != m_prev_sec);
        ok = 1;
        for (int k = 0; k < 6; k++) begin
            f = m_sh[8*k +: 8];
            if (f / 16 > 9 || f % 16 > 9) ok = 0;
        end
        h  = m_sh[23:20] * 10 + m_sh[19:16];
        hd = m_sh[23:16];
        pm = 0;
`ifdef RTC_DISP_12H_EN
        pm  = (h >= 12);
        h12 = (h % 12 == 0) ? 12 : h % 12;
        hd  = to_bcd(h12);
`else
        h12 = h;
`endif
        m_disp  = !ok ? 24'h0 : (m_view ? m_sh[47:24] : {hd, m_sh[15:0]});
        m_err   = !ok;
        m_since = tick ? 0 : m_since + 1;
        m_point = (m_view || m_since < HALF) ? 6'b010100 : 6'b000000;
        if (!m_view && pm) m_point[0] = 1'b1;
        if (key_press) begin
            m_view = !m_view;
            m_secs = 0;
        end else if (tick) begin
            m_secs++;
            if (AUTO_SEC != 0 && m_secs == AUTO_SEC) begin
                m_view = !m_view;
                m_secs = 0;
            end
        end
        m_prev_sec = m_sh[7:0];
        if (m_cur == in_w && m_cur != m_sh) m_sh = m_cur;
        m_cur = in_w;
    endtask

    task automatic compare_all();
        check("disp_data", 32'(disp_data), 32'(m_disp));
        check("point", 32'(point), 32'(m_point));
        check("view_date", 32'(view_date), 32'(m_view));
        check("bcd_err", 32'(bcd_err), 32'(m_err));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input int unsigned n);
        repeat (n) cycle();
    endtask

    task automatic press();
        key_press = 1'b1;
        cycle();
        key_press = 1'b0;
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_disp", 32'(disp_data), 32'h0);
        check("rst_point", 32'(point), 32'h0);
        check("rst_view", 32'(view_date), 32'h0);
        check("rst_err", 32'(bcd_err), 32'h0);
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    int unsigned sd;

    initial begin
        sec = 8'h56; min = 8'h34; hour = 8'h12; day = 8'h01; mon = 8'h04; year = 8'h24;
        #1;
        @(negedge clk);
        do_reset(3);

        // First snapshot reaches the display on the third edge.
        cycle(); check("lat_e1", 32'(disp_data), 32'h0);
        cycle(); check("lat_e2", 32'(disp_data), 32'h0);
        cycle(); check("lat_e3", 32'(disp_data), 32'h123456);
        check("lat_view", 32'(view_date), 32'h0);

        // Two presses return to TIME with the second counter cleared.
        hold(4); press(); hold(3); press(); hold(3);

        sec = 8'h57; hold(10);
        sec = 8'h58; hold(3);
        check("blink_on_first", 32'(point), 32'({5'b01010, PM12}));
        hold(49);
        check("blink_on_last", 32'(point), 32'({5'b01010, PM12}));
        hold(1);
        check("blink_off", 32'(point), 32'({5'b00000, PM12}));
        check("view_pre_auto", 32'(view_date), 32'h0);
        sec = 8'h59; hold(10);
        check("auto_view", 32'(view_date), 32'h1);
        check("auto_disp", 32'(disp_data), 32'h240401);
        check("auto_point", 32'(point), 32'h14);

        // Back to TIME, then a key press into DATE.
        press(); hold(5);
        key_press = 1'b1; cycle(); key_press = 1'b0;
        check("key_view", 32'(view_date), 32'h1);
        cycle();
        check("key_disp", 32'(disp_data), 32'h240401);
        sec = 8'h00; hold(5); sec = 8'h01; hold(5);
        check("key_cnt_hold", 32'(view_date), 32'h1);
        sec = 8'h02; hold(5);
        check("key_cnt_auto", 32'(view_date), 32'h0);

        // Every-cycle glitching never reaches the snapshot.
        for (int i = 0; i < 20; i++) begin
            sec = (i % 2 == 0) ? 8'h10 : 8'h11;
            cycle();
        end
        check("glitch_disp", 32'(disp_data), 32'h123402);
        sec = 8'h1A; hold(4);
        check("bad_err", 32'(bcd_err), 32'h1);
        check("bad_disp", 32'(disp_data), 32'h0);
        sec = 8'h00; hold(4);
        check("bad_clear", 32'(bcd_err), 32'h0);

        hour = 8'h00; hold(4);
`ifdef RTC_DISP_12H_EN
        check("h12_00", 32'(disp_data[23:16]), 32'h12);
        check("h12_00_pm", 32'(point[0]), 32'h0);
`endif
        hour = 8'h13; hold(4);
`ifdef RTC_DISP_12H_EN
        check("h12_13", 32'(disp_data[23:16]), 32'h01);
        check("h12_13_pm", 32'(point[0]), 32'h1);
`endif
        hour = 8'h23; hold(4);
`ifdef RTC_DISP_12H_EN
        check("h12_23", 32'(disp_data[23:16]), 32'h11);
        check("h12_23_pm", 32'(point[0]), 32'h1);
`else
        check("h24_23", 32'(disp_data[23:16]), 32'h23);
`endif

        // Mid-operation reset.
        do_reset(2);
        hold(5);

        // Randomized traffic: second ticks, field changes, glitches, keys, resets.
        sd = 0;
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7: begin
                    sd  = (sd + 1) % 60;
                    sec = to_bcd(sd);
                    hold($urandom_range(2, 70));
                end
                8, 9: begin
                    hour = to_bcd($urandom_range(0, 23));
                    min  = to_bcd($urandom_range(0, 59));
                    day  = to_bcd($urandom_range(1, 31));
                    mon  = to_bcd($urandom_range(1, 12));
                    year = to_bcd($urandom_range(0, 99));
                    hold($urandom_range(1, 6));
                end
                10, 11: begin
                    for (int g = 0; g < int'($urandom_range(2, 12)); g++) begin
                        sec = to_bcd($urandom_range(0, 59));
                        cycle();
                    end
                end
                12, 13, 14: begin
                    press();
                    hold($urandom_range(0, 4));
                end
                15: begin
                    sec = {4'($urandom_range(10, 15)), 4'($urandom_range(0, 15))};
                    hold($urandom_range(1, 8));
                end
                16: begin
                    if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
                    else hold(1);
                end
                default: hold($urandom_range(1, 10));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
